// File: rtl/poly_add_ctrl.sv
// poly_add_ctrl: streams KYBER_N coefficient pairs from two source RAMs through an adder into a destination RAM.
// Optional feature macro POLY_ADD_CTRL_MODQ_EN adds one conditional subtraction of KYBER_Q to every sum.
module poly_add_ctrl #(
    parameter int KYBER_N = 256,
    parameter int KYBER_Q = 3329,
    parameter int COEFF_W = 16,
    parameter int ADDR_W  = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stall,
    output logic               busy,
    output logic               done,
    output logic               rd_en,
    output logic [ADDR_W-1:0]  rd_addr,
    input  logic [COEFF_W-1:0] a_data,
    input  logic [COEFF_W-1:0] b_data,
    output logic               wr_en,
    output logic [ADDR_W-1:0]  wr_addr,
    output logic [COEFF_W-1:0] wr_data
);

    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(KYBER_N - 1);

    if ((KYBER_N != (1 << ADDR_W)) || (KYBER_Q <= 0) || (KYBER_Q >= (1 << COEFF_W))) begin : gBadParams
        $error("poly_add_ctrl: KYBER_N must equal 2**ADDR_W and KYBER_Q must fit in COEFF_W bits");
    end

`ifdef POLY_ADD_CTRL_MODQ_EN
    localparam logic signed [COEFF_W:0] Q_EXT = (COEFF_W + 1)'(KYBER_Q);
`endif

    state_t              state;
    state_t              stateNext;
    logic [ADDR_W-1:0]   rdAddr_p0;
    logic                vld_p1;
    logic [ADDR_W-1:0]   addr_p1;
    logic                vld_p2;
    logic [ADDR_W-1:0]   wrAddr_p2;
    logic [COEFF_W-1:0]  wrData_p2;
    logic                rdIssue;
    logic                wrIssue;

    function automatic logic [COEFF_W-1:0] addCoef(
        input logic signed [COEFF_W-1:0] a,
        input logic signed [COEFF_W-1:0] b
    );
`ifdef POLY_ADD_CTRL_MODQ_EN
        logic signed [COEFF_W:0] sum;
        sum = {a[COEFF_W-1], a} + {b[COEFF_W-1], b};
        if (sum >= Q_EXT) begin
            sum = sum - Q_EXT;
        end
        return sum[COEFF_W-1:0];
`else
        return a + b;
`endif
    endfunction

    // A write is held (not lost) while stalled; the registered strobe is only gated at the port.
    assign wrIssue = vld_p2 && !stall;

    always_comb begin
        stateNext = state;
        busy      = 1'b0;
        done      = 1'b0;
        rdIssue   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    stateNext = READ;
                end
            end
            READ: begin
                busy    = 1'b1;
                rdIssue = !stall;
                if (rdIssue && (rdAddr_p0 == LAST_ADDR)) begin
                    stateNext = DRAIN;
                end
            end
            DRAIN: begin
                busy = 1'b1;
                if (wrIssue && (wrAddr_p2 == LAST_ADDR)) begin
                    stateNext = DONE;
                end
            end
            DONE: begin
                done      = 1'b1;
                stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Stage 0: read issue; the counter parks on the last address instead of wrapping
    always_ff @(posedge clk) begin
        if (rst) begin
            rdAddr_p0 <= '0;
        end else if ((state == IDLE) && start) begin
            rdAddr_p0 <= '0;
        end else if (rdIssue && (rdAddr_p0 != LAST_ADDR)) begin
            rdAddr_p0 <= rdAddr_p0 + 1'b1;
        end
    end

    // Stage 1: RAM data returns (RAMs hold their output during stall); Stage 2: registered write
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1    <= 1'b0;
            addr_p1   <= '0;
            vld_p2    <= 1'b0;
            wrAddr_p2 <= '0;
            wrData_p2 <= '0;
        end else if (!stall) begin
            vld_p1  <= rdIssue;
            addr_p1 <= rdAddr_p0;
            vld_p2  <= vld_p1;
            if (vld_p1) begin
                wrAddr_p2 <= addr_p1;
                wrData_p2 <= addCoef(a_data, b_data);
            end
        end
    end

    assign rd_en   = rdIssue;
    assign rd_addr = rdAddr_p0;
    assign wr_en   = wrIssue;
    assign wr_addr = wrAddr_p2;
    assign wr_data = wrData_p2;

endmodule

// File: tb/tb_poly_add_ctrl.sv
// Self-checking bench for poly_add_ctrl: behavioural source RAMs, a write scoreboard and cycle-accurate timing checks.
`timescale 1ns/1ps
module tb_poly_add_ctrl;

    localparam int N  = 256;
    localparam int Q  = 3329;
    localparam int W  = 16;
    localparam int AW = 8;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [W-1:0]  data;
    } wr_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          stall;
    logic          busy;
    logic          done;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [W-1:0]  a_data = '0;
    logic [W-1:0]  b_data = '0;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [W-1:0]  wr_data;

    logic [W-1:0]  memA [N];
    logic [W-1:0]  memB [N];
    wr_t           expQ [$];

    int checks = 0;
    int errors = 0;
    int wrCount, firstWr, lastWr, doneCount, doneCyc, sbBad, rdBad, rdCount, busyFirst, busyLast;
    logic [AW-1:0]      nextRd;
    logic [35:0]        snap;
    wr_t                badExp;
    logic [AW+W-1:0]    badGot;

    poly_add_ctrl dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .stall   (stall),
        .busy    (busy),
        .done    (done),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .a_data  (a_data),
        .b_data  (b_data),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data)
    );

    always #5 clk = ~clk;

    // Source RAMs: one-cycle read latency, output held while rd_en is low.
    always @(posedge clk) begin
        if (rd_en) begin
            a_data <= memA[rd_addr];
            b_data <= memB[rd_addr];
        end
    end

    function automatic logic [W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
        int s;
        s = int'($signed(a)) + int'($signed(b));
`ifdef POLY_ADD_CTRL_MODQ_EN
        if (s >= Q) s = s - Q;
`endif
        return s[W-1:0];
    endfunction

    task automatic loadAndExpect(input bit ramp, input logic [W-1:0] ca, input logic [W-1:0] cb,
                                 input logic [W-1:0] ev);
        wr_t e;
        expQ.delete();
        for (int k = 0; k < N; k++) begin
            memA[k] = ramp ? W'(k) : ca;
            memB[k] = ramp ? W'(2 * k) : cb;
            e.addr  = AW'(k);
            e.data  = ramp ? model(memA[k], memB[k]) : ev;
            expQ.push_back(e);
        end
    endtask

    // Drives one run starting at cycle 0 (entered just after a rising edge) and records what the DUT did.
    task automatic runPoly(input int stallAt, input int stallLen, input int startA, input int startB,
                           input int rstAt, input int limit);
        wr_t e;
        wrCount = 0; firstWr = -1; lastWr = -1; doneCount = 0; doneCyc = -1;
        sbBad = 0; rdBad = 0; rdCount = 0; busyFirst = -1; busyLast = -1;
        nextRd = '0; snap = '1; badExp = '0; badGot = '0;
        for (int rel = 0; rel < limit; rel++) begin
            start = (rel == 0) || (rel == startA) || (rel == startB);
            stall = (stallAt >= 0) && (rel >= stallAt) && (rel < stallAt + stallLen);
            rst   = (rel == rstAt);
            @(negedge clk);
            if (wr_en) begin
                if (firstWr < 0) firstWr = rel;
                lastWr = rel;
                wrCount++;
                if (stall) sbBad++;
                if (expQ.size() == 0) begin
                    sbBad++;
                end else begin
                    e = expQ.pop_front();
                    if ((wr_addr !== e.addr) || (wr_data !== e.data)) begin
                        if (sbBad == 0) begin
                            badExp = e;
                            badGot = {wr_addr, wr_data};
                        end
                        sbBad++;
                    end
                end
            end
            if (rd_en) begin
                if ((rd_addr !== nextRd) || !busy || stall) rdBad++;
                nextRd++;
                rdCount++;
            end
            if (busy) begin
                if (busyFirst < 0) busyFirst = rel;
                busyLast = rel;
            end
            if (done) begin
                doneCount++;
                if (doneCyc < 0) doneCyc = rel;
            end
            if ((rstAt >= 0) && (rel == rstAt + 1)) snap = {busy, done, rd_en, wr_en, rd_addr, wr_addr, wr_data};
            if ((doneCyc >= 0) && (rel >= doneCyc + 4)) break;
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        stall = 1'b0;
        rst   = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; stall = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if ({busy, done, rd_en, wr_en} !== 4'b0000) begin errors++; $display("FAIL reset_ctrl got %b want 0000", {busy, done, rd_en, wr_en}); end
        checks++; if ({rd_addr, wr_addr} !== 16'h0000) begin errors++; $display("FAIL reset_addr got %h want 0000", {rd_addr, wr_addr}); end
        checks++; if (wr_data !== 16'h0000) begin errors++; $display("FAIL reset_data got %h want 0000", wr_data); end
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_basic_add();
        loadAndExpect(1'b1, '0, '0, '0);
        runPoly(-1, 0, -1, -1, -1, 400);
        checks++; if (sbBad !== 0) begin errors++; $display("FAIL basic_data %0d bad, first got %h want %h", sbBad, badGot, badExp); end
        checks++; if (wrCount !== N) begin errors++; $display("FAIL basic_wrcount got %0d want %0d", wrCount, N); end
        checks++; if (firstWr !== 3) begin errors++; $display("FAIL basic_firstwr got %0d want 3", firstWr); end
        checks++; if (lastWr !== 258) begin errors++; $display("FAIL basic_lastwr got %0d want 258", lastWr); end
        checks++; if (doneCyc !== 259) begin errors++; $display("FAIL basic_done got %0d want 259", doneCyc); end
        checks++; if (doneCount !== 1) begin errors++; $display("FAIL basic_donecount got %0d want 1", doneCount); end
        checks++; if ((rdBad !== 0) || (rdCount !== N)) begin errors++; $display("FAIL basic_reads bad %0d count %0d want 0 %0d", rdBad, rdCount, N); end
        checks++; if ((busyFirst !== 1) || (busyLast !== 258)) begin errors++; $display("FAIL basic_busy got %0d..%0d want 1..258", busyFirst, busyLast); end
    endtask

`ifdef POLY_ADD_CTRL_MODQ_EN
    task automatic test_modq();
        loadAndExpect(1'b0, 16'd3000, 16'd500, 16'd171);
        runPoly(-1, 0, -1, -1, -1, 400);
        checks++; if ((sbBad !== 0) || (wrCount !== N)) begin errors++; $display("FAIL modq_sub %0d bad of %0d, first got %h want %h", sbBad, wrCount, badGot, badExp); end
        loadAndExpect(1'b0, 16'd1664, 16'd1664, 16'd3328);
        runPoly(-1, 0, -1, -1, -1, 400);
        checks++; if ((sbBad !== 0) || (wrCount !== N)) begin errors++; $display("FAIL modq_nosub %0d bad of %0d, first got %h want %h", sbBad, wrCount, badGot, badExp); end
    endtask
`else
    task automatic test_signed_wrap();
        loadAndExpect(1'b0, 16'h7FFF, 16'h0001, 16'h8000);
        runPoly(-1, 0, -1, -1, -1, 400);
        checks++; if ((sbBad !== 0) || (wrCount !== N)) begin errors++; $display("FAIL wrap_pos %0d bad of %0d, first got %h want %h", sbBad, wrCount, badGot, badExp); end
        loadAndExpect(1'b0, 16'hFFFB, 16'h0003, 16'hFFFE);
        runPoly(-1, 0, -1, -1, -1, 400);
        checks++; if ((sbBad !== 0) || (wrCount !== N)) begin errors++; $display("FAIL wrap_neg %0d bad of %0d, first got %h want %h", sbBad, wrCount, badGot, badExp); end
    endtask
`endif

    task automatic test_stall();
        loadAndExpect(1'b1, '0, '0, '0);
        runPoly(100, 4, -1, -1, -1, 400);
        checks++; if (sbBad !== 0) begin errors++; $display("FAIL stall_data %0d bad, first got %h want %h", sbBad, badGot, badExp); end
        checks++; if (wrCount !== N) begin errors++; $display("FAIL stall_wrcount got %0d want %0d", wrCount, N); end
        checks++; if ((rdBad !== 0) || (rdCount !== N)) begin errors++; $display("FAIL stall_reads bad %0d count %0d want 0 %0d", rdBad, rdCount, N); end
        checks++; if (lastWr !== 262) begin errors++; $display("FAIL stall_lastwr got %0d want 262", lastWr); end
        checks++; if (doneCyc !== 263) begin errors++; $display("FAIL stall_done got %0d want 263", doneCyc); end
    endtask

    task automatic test_reset_mid_run();
        loadAndExpect(1'b1, '0, '0, '0);
        runPoly(-1, 0, -1, -1, 50, 300);
        checks++; if (snap !== 36'h0) begin errors++; $display("FAIL midrst_outputs got %h want 0", snap); end
        checks++; if (doneCount !== 0) begin errors++; $display("FAIL midrst_done got %0d want 0", doneCount); end
        checks++; if ((wrCount !== 48) || (sbBad !== 0)) begin errors++; $display("FAIL midrst_writes got %0d bad %0d want 48 0", wrCount, sbBad); end
        checks++; if (expQ.size() !== 208) begin errors++; $display("FAIL midrst_pending got %0d want 208", expQ.size()); end
        loadAndExpect(1'b1, '0, '0, '0);
        runPoly(-1, 0, -1, -1, -1, 400);
        checks++; if ((sbBad !== 0) || (wrCount !== N)) begin errors++; $display("FAIL midrst_rerun %0d bad of %0d, first got %h want %h", sbBad, wrCount, badGot, badExp); end
        checks++; if ((doneCyc !== 259) || (rdBad !== 0)) begin errors++; $display("FAIL midrst_rerun_done got %0d rdbad %0d want 259 0", doneCyc, rdBad); end
    endtask

    task automatic test_start_while_busy();
        loadAndExpect(1'b1, '0, '0, '0);
        runPoly(-1, 0, 10, 258, -1, 400);
        checks++; if ((doneCount !== 1) || (doneCyc !== 259)) begin errors++; $display("FAIL busystart_done count %0d at %0d want 1 at 259", doneCount, doneCyc); end
        checks++; if ((wrCount !== N) || (sbBad !== 0)) begin errors++; $display("FAIL busystart_writes got %0d bad %0d want %0d 0", wrCount, sbBad, N); end
        checks++; if ((rdCount !== N) || (busyLast !== 258)) begin errors++; $display("FAIL busystart_reads got %0d busy to %0d want %0d 258", rdCount, busyLast, N); end
    endtask

    initial begin
        test_reset();
        test_basic_add();
`ifdef POLY_ADD_CTRL_MODQ_EN
        test_modq();
`else
        test_signed_wrap();
`endif
        test_stall();
        test_reset_mid_run();
        test_start_while_busy();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
